// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram-stretch coefficient controller.
package hist_pkg;

  localparam int DW_DEF        = 8;
  localparam int FRAC_DEF      = 8;
  localparam int MIN_RANGE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CHECK,
    DIVIDE,
    READY
  } hist_state_t;

  function automatic logic [15:0] gain_one(input int frac);
    return 16'(1 << frac);
  endfunction

  // Full-scale gray level scaled into the gain's fixed-point format.
  function automatic logic [15:0] div_num(input int dw, input int frac);
    return 16'(((1 << dw) - 1) << frac);
  endfunction

  localparam logic [15:0] GAIN_ONE = gain_one(FRAC_DEF);
  localparam logic [15:0] DIV_NUM  = div_num(DW_DEF, FRAC_DEF);

endpackage

// File: rtl/hist_div_serial.sv
// Restoring serial divider, one quotient bit per cycle. The first bit is
// produced in the start cycle so done arrives a fixed NW cycles after start.
module hist_div_serial #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(NW);

  logic [DW-1:0] rem_reg;
  logic [DW-1:0] div_reg;
  logic [NW-1:0] quo_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [DW-1:0] step_rem_in;
  logic [DW-1:0] step_div;
  logic [NW-1:0] step_quo_in;
  logic [DW:0]   trial;
  logic          trial_ge;
  logic [DW-1:0] rem_next;
  logic [NW-1:0] quo_next;

  // quo_reg shifts dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    if (busy_reg) begin
      step_rem_in = rem_reg;
      step_quo_in = quo_reg;
      step_div    = div_reg;
    end else begin
      step_rem_in = '0;
      step_quo_in = dividend;
      step_div    = divisor;
    end
    trial    = {step_rem_in, step_quo_in[NW-1]};
    trial_ge = (trial >= {1'b0, step_div});
    rem_next = trial_ge ? DW'(trial - {1'b0, step_div}) : trial[DW-1:0];
    quo_next = {step_quo_in[NW-2:0], trial_ge};
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      rem_reg  <= '0;
      div_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end else if (start) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        div_reg  <= divisor;
        cnt_reg  <= CW'(NW - 1);
        busy_reg <= 1'b1;
      end
    end
  end

  assign quotient = quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/hist_stretch_ctrl.sv
// Per-frame gain/offset controller: computes coefficients from frame min/max
// into a shadow set and commits them to the datapath only at frame start.
module hist_stretch_ctrl
  import hist_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int MIN_RANGE = MIN_RANGE_DEF
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          i_vsync,
  input  logic          stat_valid,
  input  logic [DW-1:0] stat_min,
  input  logic [DW-1:0] stat_max,
  input  logic          cfg_enable,
  input  logic          cfg_manual,
  input  logic [DW-1:0] cfg_min,
  input  logic [DW-1:0] cfg_max,
  output logic [15:0]   o_gain,
  output logic [DW-1:0] o_offset,
  output logic          o_bypass,
  output logic          o_commit,
  output logic          o_busy,
  output logic          o_late,
  output logic          o_err
);

  localparam logic [15:0]   GAIN_ONE_P = gain_one(FRAC);
  localparam logic [15:0]   DIV_NUM_P  = div_num(DW, FRAC);
  localparam logic [DW-1:0] MIN_SPAN   = DW'(MIN_RANGE);

  hist_state_t state_reg, state_next;

  logic          vsync_reg;
  logic          vs_rise;
  logic [DW-1:0] src_min, src_max;
  logic [DW-1:0] in_min_reg, in_max_reg;
  logic [DW-1:0] pend_min_reg, pend_max_reg;
  logic          pend_reg;
  logic [DW-1:0] span;
  logic          inverted;

  logic [15:0]   shadow_gain_reg;
  logic [DW-1:0] shadow_off_reg;
  logic          shadow_byp_reg;
  logic [15:0]   gain_reg;
  logic [DW-1:0] off_reg;
  logic          byp_reg;
  logic          commit_reg, late_reg, err_reg;

  logic          div_start, div_done;
  logic [15:0]   div_quot;

  logic set_bypass, set_div, do_commit, late_now;
  logic load_new, load_pend, store_pend;

  assign vs_rise  = i_vsync & ~vsync_reg;
  assign src_min  = cfg_manual ? cfg_min : stat_min;
  assign src_max  = cfg_manual ? cfg_max : stat_max;
  assign span     = in_max_reg - in_min_reg;
  assign inverted = (in_min_reg > in_max_reg);

  always_ff @(posedge pixelclk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    set_bypass = 1'b0;
    set_div    = 1'b0;
    do_commit  = 1'b0;
    late_now   = 1'b0;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    case (state_reg)
      IDLE: begin
        if (stat_valid) begin
          load_new   = 1'b1;
          state_next = LATCH;
        end
      end
      LATCH: state_next = CHECK;
      CHECK: begin
        if (inverted || !cfg_enable || span < MIN_SPAN) begin
          set_bypass = 1'b1;
          state_next = READY;
        end else begin
          div_start  = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          set_div    = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (vs_rise) begin
          do_commit = 1'b1;
          // A fresh sample arriving with the frame start supersedes any pending one.
          if (stat_valid) begin
            load_new   = 1'b1;
            state_next = LATCH;
          end else if (pend_reg) begin
            load_pend  = 1'b1;
            state_next = LATCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (stat_valid && state_reg != IDLE && !load_new) store_pend = 1'b1;
    if (vs_rise && (state_reg == LATCH || state_reg == CHECK || state_reg == DIVIDE))
      late_now = 1'b1;
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vsync_reg       <= 1'b0;
      in_min_reg      <= '0;
      in_max_reg      <= '0;
      pend_min_reg    <= '0;
      pend_max_reg    <= '0;
      pend_reg        <= 1'b0;
      shadow_gain_reg <= GAIN_ONE_P;
      shadow_off_reg  <= '0;
      shadow_byp_reg  <= 1'b1;
      gain_reg        <= GAIN_ONE_P;
      off_reg         <= '0;
      byp_reg         <= 1'b1;
      commit_reg      <= 1'b0;
      late_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      vsync_reg  <= i_vsync;
      commit_reg <= do_commit;
      late_reg   <= late_now;

      if (load_new) begin
        in_min_reg <= src_min;
        in_max_reg <= src_max;
      end else if (load_pend) begin
        in_min_reg <= pend_min_reg;
        in_max_reg <= pend_max_reg;
      end

      if (store_pend) begin
        pend_min_reg <= src_min;
        pend_max_reg <= src_max;
        pend_reg     <= 1'b1;
      end else if (load_new || load_pend) begin
        pend_reg <= 1'b0;
      end

      if (state_reg == CHECK && inverted) err_reg <= 1'b1;

      if (set_bypass) begin
        shadow_gain_reg <= GAIN_ONE_P;
        shadow_off_reg  <= '0;
        shadow_byp_reg  <= 1'b1;
      end else if (set_div) begin
        shadow_gain_reg <= div_quot;
        shadow_off_reg  <= in_min_reg;
        shadow_byp_reg  <= 1'b0;
      end

      if (do_commit) begin
        gain_reg <= shadow_gain_reg;
        off_reg  <= shadow_off_reg;
        byp_reg  <= shadow_byp_reg;
      end
    end
  end

  hist_div_serial #(
    .NW(16),
    .DW(DW)
  ) u_div (
    .pixelclk (pixelclk),
    .reset    (reset),
    .start    (div_start),
    .dividend (DIV_NUM_P),
    .divisor  (span),
    .quotient (div_quot),
    .done     (div_done)
  );

  assign o_gain   = gain_reg;
  assign o_offset = off_reg;
  assign o_bypass = byp_reg;
  assign o_commit = commit_reg;
  assign o_busy   = (state_reg == LATCH) || (state_reg == CHECK) || (state_reg == DIVIDE);
  assign o_late   = late_reg;
  assign o_err    = err_reg;

endmodule

// File: doc/hist_stretch_ctrl.md
Name: hist_stretch_ctrl

Overview:
Per-frame coefficient controller for the histogram-stretch pixel datapath. It takes each frame's gray min/max, from the minmax statistics block or from manual config registers, and computes gain = floor(255·2^FRAC/(max−min)) and offset = min with a serial divider. It holds the result in a shadow register and commits it to the datapath only at the next frame start, so coefficients never change mid-frame. It sits between the minmax statistics block and the stretch multiplier stage, all in the pixelclk domain.

Parameters:
DW, 8, gray sample width
FRAC, 8, fractional bits of gain (gain is unsigned (16−FRAC).FRAC)
MIN_RANGE, 16, smallest max−min span that is stretched; smaller spans force bypass

Ports:
pixelclk  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
i_vsync  in  1  frame sync; rising edge = frame start = commit point
stat_valid  in  1  one-cycle pulse: stat_min/stat_max hold the finished frame's values
stat_min  in  DW  measured frame minimum
stat_max  in  DW  measured frame maximum
cfg_enable  in  1  0 = force bypass at next commit
cfg_manual  in  1  1 = use cfg_min/cfg_max instead of stat_*
cfg_min  in  DW  manual minimum
cfg_max  in  DW  manual maximum
o_gain  out  16  active gain, FRAC fractional bits
o_offset  out  DW  active offset (subtracted before gain)
o_bypass  out  1  1 = datapath passes gray through unchanged
o_commit  out  1  one-cycle pulse when active coefficients update
o_busy  out  1  FSM not in IDLE/READY
o_late  out  1  one-cycle pulse: frame start arrived before the new coefficients were ready
o_err  out  1  sticky; set when min>max is sampled; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): o_gain=2^FRAC (0x0100), o_offset=0, o_bypass=1, o_commit=0, o_busy=0, o_late=0, o_err=0, FSM=IDLE, shadow registers equal the active ones, pending flag clear.
- vsync_r is i_vsync registered. vs_rise = i_vsync & ~vsync_r.
- FSM states:
  - IDLE: on stat_valid go to LATCH.
  - LATCH: capture min/max from the cfg or stat source. cfg_manual is sampled in the stat_valid cycle. 1 cycle.
  - CHECK: 1 cycle. Compute span=max−min.
    - min>max: set o_err; shadow = bypass, gain 0x0100, offset 0; go to READY.
    - !cfg_enable or span<MIN_RANGE: same bypass shadow; go to READY.
    - Otherwise start the divider with dividend 255<<FRAC and divisor span; go to DIVIDE.
  - DIVIDE: 16 cycles, restoring, one quotient bit per cycle. On done, shadow gain=quotient, offset=min, bypass=0; go to READY.
  - READY: wait for vs_rise. Then copy shadow to active, pulse o_commit, and go to IDLE, or to LATCH if pending is set.
- Latency: stat_valid to READY is 18 cycles (LATCH 1 + CHECK 1 + DIVIDE 16). Commit happens on the cycle after vs_rise is detected.
- vs_rise while in LATCH/CHECK/DIVIDE: active coefficients stay unchanged and o_late pulses. The computation continues and commits at the following vs_rise.
- stat_valid while busy or in READY: the new min/max are stored in a pending slot (newest wins) and processed after the current commit. Nothing is dropped silently except older pending values.
- stat_valid and vs_rise in the same cycle while in READY: commit first, then go to LATCH with the new values.
- Arithmetic: unsigned integer math, quotient truncated. The maximum gain is 4080 (span 16), so there is no overflow in 16 bits. Span 255 gives exactly 0x0100.
- Reset mid-DIVIDE aborts the division and restores all reset values; no o_commit is issued.

Decomposition:
- Shared package hist_pkg holds:
  - FSM state enum {IDLE, LATCH, CHECK, DIVIDE, READY}
  - GAIN_ONE = 1<<FRAC
  - DIV_NUM = 255<<FRAC
  - default MIN_RANGE and FRAC
- Sub-module hist_div_serial: 16-bit-by-8-bit restoring serial divider with start/done handshake, fixed 16-cycle latency.
  - start is ignored while busy.
  - done is a 1-cycle pulse with the quotient held until the next start.

Test Plan:
- Reset, then idle 10 cycles -> o_gain=0x0100, o_offset=0, o_bypass=1, o_commit never pulses.
- stat_valid with min=50, max=200; vs_rise 30 cycles later -> o_commit pulses one cycle after vs_rise; o_gain=0x01B3 (435), o_offset=50, o_bypass=0.
- min=0/255 -> gain 0x0100. min=100/116 -> gain 0x0FF0. min=100/115 -> o_bypass=1, gain 0x0100, offset 0.
- stat_valid then vs_rise 5 cycles later -> o_late pulses, old coefficients remain; next vs_rise commits the new values.
- min=200, max=100 -> o_err=1 and stays set; the commit gives bypass. cfg_manual=1 with cfg 10/138 overrides stats -> gain 0x01FE (510), offset 10.
- Reset asserted at DIVIDE cycle 8 -> all outputs return to reset values; no o_commit at the next vs_rise.
